// File: rtl/fsk_rate_ctrl.sv
// FSK symbol-rate sequencer: takes bits over valid/ready and drives a
// phase-continuous square-wave carrier, one divisor per bit value.
module fsk_rate_ctrl #(
    parameter int D0      = 10000,
    parameter int D1      = 5000,
    parameter int SYM_LEN = 100000,
    parameter int CW      = 27
) (
    input  logic inclk,
    input  logic rst_n,
    input  logic bit_in,
    input  logic bit_valid,
    output logic bit_ready,
    output logic carrier_out,
    output logic sym_strobe,
    output logic underrun,
    output logic busy
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [CW-1:0] HALF0    = CW'(D0 / 2);
    localparam logic [CW-1:0] HALF1    = CW'(D1 / 2);
    localparam logic [CW-1:0] SYM_LAST = CW'(SYM_LEN - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    state_t        state;
    logic          cur_bit;
    logic          nxt_bit;
    logic          nxt_valid;
    logic [CW-1:0] div_act;
    logic [CW-1:0] hcnt;
    logic [CW-1:0] sym_cnt;

    logic xfer;
    logic tog;
    logic sym_end;
    logic have_next;
    logic next_bit;
    logic new_cur;

    assign bit_ready = (state == IDLE) || ((state == RUN) && !nxt_valid);
    assign busy      = (state != IDLE);
    assign xfer      = bit_valid && bit_ready;
    assign tog       = (hcnt == div_act - ONE);
    assign sym_end   = (sym_cnt == SYM_LAST);

    // A bit arriving in the symbol-end cycle bypasses the empty buffer.
    assign have_next = nxt_valid || xfer;
    assign next_bit  = nxt_valid ? nxt_bit : bit_in;
    assign new_cur   = (sym_end && have_next) ? next_bit : cur_bit;

    always_ff @(posedge inclk) begin
        if (!rst_n) begin
            state       <= IDLE;
            carrier_out <= 1'b0;
            sym_strobe  <= 1'b0;
            underrun    <= 1'b0;
            cur_bit     <= 1'b0;
            nxt_bit     <= 1'b0;
            nxt_valid   <= 1'b0;
            div_act     <= '0;
            hcnt        <= '0;
            sym_cnt     <= '0;
        end else begin
            sym_strobe <= 1'b0;
            underrun   <= 1'b0;
            case (state)
                IDLE: begin
                    if (xfer) begin
                        cur_bit    <= bit_in;
                        div_act    <= bit_in ? HALF1 : HALF0;
                        hcnt       <= '0;
                        sym_cnt    <= '0;
                        sym_strobe <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    hcnt    <= tog ? '0 : hcnt + ONE;
                    sym_cnt <= sym_end ? '0 : sym_cnt + ONE;
                    // Divisor only moves on a toggle so half-periods stay whole.
                    if (tog) begin
                        carrier_out <= ~carrier_out;
                        div_act     <= new_cur ? HALF1 : HALF0;
                    end
                    if (sym_end) begin
                        if (have_next) begin
                            cur_bit    <= next_bit;
                            sym_strobe <= 1'b1;
                            nxt_valid  <= 1'b0;
                        end else begin
                            underrun <= 1'b1;
                            state    <= (tog && carrier_out) ? IDLE : DRAIN;
                        end
                    end else if (xfer) begin
                        nxt_bit   <= bit_in;
                        nxt_valid <= 1'b1;
                    end
                end
                DRAIN: begin
                    hcnt <= tog ? '0 : hcnt + ONE;
                    // Park low at the next half-period boundary, never mid-pulse.
                    if (tog) begin
                        carrier_out <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fsk_rate_ctrl.sv
// Bench for fsk_rate_ctrl: two parameter sets checked every cycle against an
// event-time model, plus directed literal checks and a randomized phase.
module tb_fsk_rate_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic bit_in = 1'b0;
    logic bit_valid = 1'b0;
    logic ready_a, car_a, str_a, und_a, busy_a;
    logic ready_b, car_b, str_b, und_b, busy_b;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    bit chk_en = 0;
    bit t5_on = 0;

    always #5 clk = ~clk;

    // A: D0=8 D1=4 SYM_LEN=16 (symbol ends always land on a toggle)
    fsk_rate_ctrl #(.D0(8), .D1(4), .SYM_LEN(16), .CW(8)) dut_a (
        .inclk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(ready_a), .carrier_out(car_a), .sym_strobe(str_a),
        .underrun(und_a), .busy(busy_a));

    // B: D1=6 so bit-1 symbols end mid half-period and exercise the drain path
    fsk_rate_ctrl #(.D0(8), .D1(6), .SYM_LEN(16), .CW(8)) dut_b (
        .inclk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(ready_b), .carrier_out(car_b), .sym_strobe(str_b),
        .underrun(und_b), .busy(busy_b));

    // Model keeps absolute edge times of the next carrier flip and symbol end.
    typedef struct {
        int mode;      // 0 idle, 1 sending, 2 parking the carrier
        int flip_at;
        int end_at;
        int half;
        bit cur;
        bit level;
        bit strobe;
        bit under;
        bit held;
        bit held_bit;
    } mdl_t;

    mdl_t ma, mb;

    function automatic bit mrdy(mdl_t m);
        return (m.mode == 0) || (m.mode == 1 && !m.held);
    endfunction

    function automatic mdl_t mstep(mdl_t m, int now, bit rstn, bit vin, bit din,
                                   int d0h, int d1h, int slen);
        mdl_t n;
        bit take, flip, ends;
        n = m;
        n.strobe = 0;
        n.under = 0;
        if (!rstn) begin
            n.mode = 0;
            n.level = 0;
            n.held = 0;
            return n;
        end
        take = vin && mrdy(m);
        if (m.mode == 0) begin
            if (take) begin
                n.mode = 1;
                n.cur = din;
                n.half = din ? d1h : d0h;
                n.flip_at = now + n.half;
                n.end_at = now + slen;
                n.strobe = 1;
            end
        end else begin
            flip = (now == m.flip_at);
            if (m.mode == 2) begin
                if (flip) begin
                    n.level = 0;
                    n.mode = 0;
                end
            end else begin
                ends = (now == m.end_at);
                if (ends) begin
                    n.end_at = now + slen;
                    if (m.held || take) begin
                        n.cur = m.held ? m.held_bit : din;
                        n.held = 0;
                        n.strobe = 1;
                    end else begin
                        n.under = 1;
                        n.mode = (flip && m.level) ? 0 : 2;
                    end
                end else if (take) begin
                    n.held = 1;
                    n.held_bit = din;
                end
                if (flip) begin
                    n.level = !m.level;
                    n.half = n.cur ? d1h : d0h;
                    n.flip_at = now + n.half;
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        ma <= mstep(ma, cyc, rst_n, bit_valid, bit_in, 4, 2, 16);
        mb <= mstep(mb, cyc, rst_n, bit_valid, bit_in, 4, 3, 16);
        cyc <= cyc + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_ok(input string nm, input bit ok, input int val);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got value %0d, not allowed (cycle %0d)", nm, val, cyc);
        end
    endtask

    int last_str = -1;
    int last_chg = -1;
    logic prev_car = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_carrier", car_a, ma.level);
            chk("a_strobe", str_a, ma.strobe);
            chk("a_underrun", und_a, ma.under);
            chk("a_busy", busy_a, ma.mode != 0);
            chk("a_ready", ready_a, mrdy(ma));
            chk("b_carrier", car_b, mb.level);
            chk("b_strobe", str_b, mb.strobe);
            chk("b_underrun", und_b, mb.under);
            chk("b_busy", busy_b, mb.mode != 0);
            chk("b_ready", ready_b, mrdy(mb));
        end
        if (t5_on) begin
            if (str_a === 1'b1) begin
                if (last_str >= 0) chk("t5_strobe_gap", cyc - last_str, 16);
                last_str <= cyc;
            end
            if (car_a !== prev_car) begin
                if (last_chg >= 0)
                    chk_ok("t5_half_len", (cyc - last_chg) == 2 || (cyc - last_chg) == 4,
                           cyc - last_chg);
                last_chg <= cyc;
            end
        end else begin
            last_str <= -1;
            last_chg <= -1;
        end
        prev_car <= car_a;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bit_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (ma.mode == 0 && mb.mode == 0) return;
            tick();
        end
        chk_ok("idle_timeout", 1'b0, 200);
    endtask

    int ps[4] = '{5, 40, 85, 100};
    int p;
    bit e;

    initial begin
        tick();
        tick();
        chk_en = 1;
        chk("reset_ready_a", ready_a, 1);
        chk("reset_carrier_a", car_a, 0);
        chk("reset_busy_a", busy_a, 0);
        rst_n = 1'b1;
        tick();

        // 1: reset mid-run while carrier high, then a fresh symbol
        bit_in = 1'b0;
        bit_valid = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 1) bit_valid = 1'b0;
            if (k == 6) begin
                chk("t1_car_high", car_a, 1);
                rst_n = 1'b0;
            end
        end
        chk("t1_car_after_rst", car_a, 0);
        chk("t1_busy_after_rst", busy_a, 0);
        chk("t1_ready_after_rst", ready_a, 1);
        chk("t1_model_car", ma.level, 0);
        rst_n = 1'b1;
        bit_valid = 1'b1;
        bit_in = 1'b1;
        tick();
        bit_valid = 1'b0;
        chk("t1_restart_strobe", str_a, 1);
        chk("t1_model_strobe", ma.strobe, 1);
        wait_idle();

        // 2: single bit 0
        bit_in = 1'b0;
        bit_valid = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k == 1) bit_valid = 1'b0;
            e = (k >= 5 && k <= 8) || (k >= 13 && k <= 16);
            chk("t2_car", car_a, e);
            chk("t2_model_car", ma.level, e);
            chk("t2_strobe", str_a, k == 1);
            chk("t2_underrun", und_a, k == 17);
            chk("t2_model_underrun", ma.under, k == 17);
            chk("t2_busy", busy_a, k <= 16);
        end
        chk("t2_ready_end", ready_a, 1);
        wait_idle();

        // 3: bits 0 then 1, second accepted at T+2 into the buffer
        bit_in = 1'b0;
        bit_valid = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (k == 1) bit_valid = 1'b0;
            if (k == 2) begin
                bit_in = 1'b1;
                bit_valid = 1'b1;
            end
            if (k == 3) bit_valid = 1'b0;
            chk("t3_ready", ready_a, !(k >= 3 && k <= 16));
            chk("t3_strobe", str_a, k == 1 || k == 17);
            chk("t3_underrun", und_a, 0);
            if (k <= 16) e = (k >= 5 && k <= 8) || (k >= 13 && k <= 16);
            else e = ((k - 17) / 2) % 2 == 1;
            chk("t3_car", car_a, e);
            chk("t3_model_car", ma.level, e);
        end
        wait_idle();

        // 4: bit 1, then bit 0 offered only in the symbol-end cycle (bypass)
        bit_in = 1'b1;
        bit_valid = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            tick();
            if (k == 1) bit_valid = 1'b0;
            if (k == 16) begin
                bit_in = 1'b0;
                bit_valid = 1'b1;
            end
            if (k == 17) bit_valid = 1'b0;
            if (k <= 16) e = ((k - 1) / 2) % 2 == 1;
            else e = (k == 21);
            chk("t4_car", car_a, e);
            chk("t4_model_car", ma.level, e);
            chk("t4_strobe", str_a, k == 1 || k == 17);
            chk("t4_underrun", und_a, 0);
            chk("t4_ready", ready_a, 1);
        end
        wait_idle();

        // 5: valid held high, data alternating per accepted bit
        bit_in = 1'b0;
        bit_valid = 1'b1;
        t5_on = 1;
        for (int k = 0; k < 72; k++) begin
            tick();
            if (mrdy(ma)) bit_in = ~bit_in;
        end
        t5_on = 0;
        bit_valid = 1'b0;
        wait_idle();

        // 6: bit 1 on B ends mid half-period with carrier high -> drain
        bit_in = 1'b1;
        bit_valid = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 1) bit_valid = 1'b0;
            e = (k >= 4 && k <= 6) || (k >= 10 && k <= 12) || (k >= 16 && k <= 18);
            chk("t6_car_b", car_b, e);
            chk("t6_model_car_b", mb.level, e);
            chk("t6_busy_b", busy_b, k <= 18);
            chk("t6_ready_b", ready_b, !(k == 17 || k == 18));
            chk("t6_underrun_b", und_b, k == 17);
        end
        wait_idle();

        // randomized traffic with varying load and rare resets
        p = 50;
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) p = ps[$urandom_range(0, 3)];
            bit_valid = ($urandom_range(0, 99) < p);
            bit_in = 1'($urandom_range(0, 1));
            rst_n = ($urandom_range(0, 599) != 0);
            tick();
        end
        rst_n = 1'b1;
        bit_valid = 1'b0;
        wait_idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
